// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared state encoding and irq id helpers for irq_arbiter
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    SERVICE  = 2'd2
  } state_t;

  localparam int IRQ_NONE = 0;

  // Processor-facing id of source k; 0 is reserved for "no request".
  function automatic int irq_encode(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/irq_select.sv
// rtl/irq_select.sv - combinational picker: first pending source at or after start, wrapping
module irq_select #(
  parameter int N_SRC = 2,
  parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [IDX_W-1:0] start,
  output logic             valid,
  output logic [IDX_W-1:0] sel
);

  logic [N_SRC-1:0] rotated;
  logic [IDX_W-1:0] offset;
  logic [IDX_W:0]   sum;

  // Rotate so start sits at bit 0, take the lowest set bit, then map back modulo N_SRC.
  always_comb begin
    rotated = N_SRC'({pending, pending} >> start);
    valid   = |pending;
    offset  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IDX_W'(i);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (IDX_W+1)'(N_SRC)) sum = sum - (IDX_W+1)'(N_SRC);
    sel = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - single-in-flight interrupt arbiter; IRQ_ROUND_ROBIN_EN selects round-robin
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int IRQ_W = $clog2(N_SRC + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] pIrq,
  output logic [N_SRC-1:0] pIack,
  output logic [N_SRC-1:0] pIend,
  output logic [IRQ_W-1:0] irq,
  input  logic             iack,
  input  logic             iend
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t           state;
  logic [N_SRC-1:0] pIrq_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] cur_onehot;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel;
  logic             sel_valid;

  assign rise       = pIrq & ~pIrq_q;
  assign cur_onehot = N_SRC'(1) << cur;

  assign irq   = (state == DISPATCH) ? IRQ_W'(irq_encode(int'(cur))) : IRQ_W'(IRQ_NONE);
  assign pIack = (state == DISPATCH && iack) ? cur_onehot : '0;
  assign pIend = (state == SERVICE && iend) ? cur_onehot : '0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last;

  // Search begins just past the most recently dispatched source.
  always_comb begin
    if (last == IDX_W'(N_SRC - 1)) start = '0;
    else                           start = last + IDX_W'(1);
  end

  // Remember the source each time DISPATCH is entered.
  always_ff @(posedge CLK) begin
    if (RESET)                         last <= '0;
    else if (state == IDLE && sel_valid) last <= sel;
  end
`else
  assign start = '0;
`endif

  irq_select #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_select (
    .pending (pending),
    .start   (start),
    .valid   (sel_valid),
    .sel     (sel)
  );

  // Request capture and the IDLE -> DISPATCH -> SERVICE handshake sequence.
  always_ff @(posedge CLK) begin
    // Sampled even in reset so a level already high at release is not seen as a new rise.
    pIrq_q <= pIrq;
    if (RESET) begin
      state   <= IDLE;
      pending <= '0;
      cur     <= '0;
    end else begin
      pending <= (pending & ~pIack) | rise;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            cur   <= sel;
            state <= DISPATCH;
          end
        end
        DISPATCH: if (iack) state <= SERVICE;
        SERVICE:  if (iend) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
